// File: rtl/exp_taylor.sv
// Fixed-point e^x for the softmax stage: one signed Q3.9 sample per transaction,
// evaluated as an iterative Taylor series, one term per clock.
module exp_taylor #(
    parameter int DATA_WIDTH = 12,
    parameter int FRACTION   = 9,
    parameter int TERMS      = 10,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sat
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    localparam int PROD_W = ACC_WIDTH + DATA_WIDTH;

    // 0x2C6 = ln(4) in Q3.9: anything at or above overflows the output range
    localparam logic signed [DATA_WIDTH-1:0] X_HI    = DATA_WIDTH'(710);
    localparam logic signed [DATA_WIDTH-1:0] X_LO    = DATA_WIDTH'(-(2 << FRACTION));
    localparam logic signed [ACC_WIDTH-1:0]  ONE     = ACC_WIDTH'(1 << FRACTION);
    localparam logic signed [ACC_WIDTH-1:0]  OUT_MAX = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic [3:0]                   N_LAST  = 4'(TERMS - 1);

    function automatic logic signed [ACC_WIDTH-1:0] factorial(input logic [3:0] n);
        case (n)
            4'd2:    factorial = ACC_WIDTH'(2);
            4'd3:    factorial = ACC_WIDTH'(6);
            4'd4:    factorial = ACC_WIDTH'(24);
            4'd5:    factorial = ACC_WIDTH'(120);
            4'd6:    factorial = ACC_WIDTH'(720);
            4'd7:    factorial = ACC_WIDTH'(5040);
            4'd8:    factorial = ACC_WIDTH'(40320);
            4'd9:    factorial = ACC_WIDTH'(362880);
            default: factorial = ACC_WIDTH'(1);
        endcase
    endfunction

    logic [1:0]                   r_state;
    logic signed [DATA_WIDTH-1:0] r_x;
    logic signed [ACC_WIDTH-1:0]  r_p;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic [3:0]                   r_n;
    logic                         r_force;
    logic                         r_clamp;
    logic [DATA_WIDTH-1:0]        r_m_data;
    logic                         r_m_sat;

    logic signed [DATA_WIDTH-1:0] w_x_in;
    logic signed [DATA_WIDTH-1:0] w_x_lat;
    logic signed [PROD_W-1:0]     w_prod;
    logic signed [ACC_WIDTH-1:0]  w_p_next;
    logic signed [ACC_WIDTH-1:0]  w_fact;
    logic signed [ACC_WIDTH-1:0]  w_term;
    logic signed [ACC_WIDTH-1:0]  w_acc_next;
    logic [DATA_WIDTH-1:0]        w_out_data;
    logic                         w_out_sat;
    logic                         w_unused;

    assign w_x_in  = s_data;
    assign w_x_lat = (w_x_in < X_LO) ? X_LO : w_x_in;

    // Bits [FRACTION +: ACC_WIDTH] are the low ACC_WIDTH bits of (P*x) >>> FRACTION
    assign w_prod     = r_p * r_x;
    assign w_p_next   = w_prod[FRACTION +: ACC_WIDTH];
    assign w_fact     = factorial(r_n);
    assign w_term     = w_p_next / w_fact;
    assign w_acc_next = r_acc + w_term;
    assign w_unused   = ^{w_prod[PROD_W-1:FRACTION+ACC_WIDTH], w_prod[FRACTION-1:0]};

    always_comb begin
        w_out_data = w_acc_next[DATA_WIDTH-1:0];
        w_out_sat  = r_clamp;
        if (r_force) begin
            w_out_data = OUT_MAX[DATA_WIDTH-1:0];
            w_out_sat  = 1'b1;
        end else if (w_acc_next < 0) begin
            w_out_data = '0;
        end else if (w_acc_next > OUT_MAX) begin
            w_out_data = OUT_MAX[DATA_WIDTH-1:0];
            w_out_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_x      <= '0;
            r_p      <= '0;
            r_acc    <= '0;
            r_n      <= '0;
            r_force  <= 1'b0;
            r_clamp  <= 1'b0;
            r_m_data <= '0;
            r_m_sat  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_valid) begin
                        r_x     <= w_x_lat;
                        r_force <= (w_x_in >= X_HI);
                        r_clamp <= (w_x_in < X_LO);
                        r_p     <= ONE;
                        r_acc   <= ONE;
                        r_n     <= 4'd1;
                        r_state <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    r_p   <= w_p_next;
                    r_acc <= w_acc_next;
                    r_n   <= r_n + 4'd1;
                    if (r_n == N_LAST) begin
                        r_m_data <= w_out_data;
                        r_m_sat  <= w_out_sat;
                        r_state  <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_ready = (r_state == ST_IDLE);
    assign m_valid = (r_state == ST_HOLD);
    assign m_data  = r_m_data;
    assign m_sat   = r_m_sat;

endmodule

// File: tb/tb_exp_taylor.sv
// Self-checking bench for exp_taylor: directed vector table, random samples against an
// arithmetic reference model, plus backpressure and mid-compute reset sequences.
module tb_exp_taylor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [11:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [11:0] m_data;
    logic        m_sat;

    int n_tests = 0;
    int n_fail  = 0;

    exp_taylor dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_sat   (m_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint wrap24(input longint v);
        longint r;
        r = v & 64'hFF_FFFF;
        if (r >= 64'h80_0000) r = r - 64'h100_0000;
        return r;
    endfunction

    // e^x = sum x^n/n!, with each power rescaled to Q.9 and each term truncated
    function automatic logic [12:0] ref_exp(input logic [11:0] x_bits);
        longint x, p, acc, fact;
        logic   sat, force_max;
        logic [11:0] d;
        x = longint'($signed(x_bits));
        sat = 1'b0;
        force_max = 1'b0;
        if (x >= 710) begin
            force_max = 1'b1;
            sat = 1'b1;
        end
        if (x < -1024) begin
            x = -1024;
            sat = 1'b1;
        end
        p = 512;
        acc = 512;
        fact = 1;
        for (int n = 1; n < 10; n++) begin
            fact = fact * n;
            p = wrap24((p * x) >>> 9);
            acc = wrap24(acc + p / fact);
        end
        if (force_max) d = 12'h7FF;
        else if (acc < 0) d = 12'h000;
        else if (acc > 2047) begin
            d = 12'h7FF;
            sat = 1'b1;
        end else d = 12'(acc);
        return {sat, d};
    endfunction

    // One full transaction; checks latency and the output handshake.
    task automatic xact(input logic [11:0] x, input bit pre_ready, input int delay,
                        output logic [11:0] d, output logic s);
        int lat;
        @(negedge clk);
        chk("s_ready_idle", s_ready, 1);
        s_valid = 1'b1;
        s_data  = x;
        m_ready = pre_ready;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 12'($urandom);
        lat = 0;
        while (!m_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 9);
        d = m_data;
        s = m_sat;
        if (!pre_ready) begin
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                chk("hold_stable", {m_valid, m_sat, m_data}, {1'b1, s, d});
            end
            m_ready = 1'b1;
        end
        @(negedge clk);
        m_ready = 1'b0;
        chk("m_valid_drop", m_valid, 0);
        chk("s_ready_after", s_ready, 1);
    endtask

    typedef struct {
        logic [11:0] x;
        logic [11:0] d;
        logic        s;
        bit          pre_ready;
        int          delay;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [11:0] d;
        logic        s;
        logic [12:0] r;
        logic [11:0] x;
        int          lat;
        bit          saw;

        vecs[0] = '{12'h000, 12'h200, 1'b0, 1'b1, 0};
        vecs[1] = '{12'h200, 12'h56E, 1'b0, 1'b0, 0};
        vecs[2] = '{12'hE00, 12'h0BC, 1'b0, 1'b0, 2};
        vecs[3] = '{12'h100, 12'h34B, 1'b0, 1'b1, 0};
        vecs[4] = '{12'h2C6, 12'h7FF, 1'b1, 1'b0, 1};
        vecs[5] = '{12'h800, 12'h046, 1'b1, 1'b0, 0};
        vecs[6] = '{12'hC00, 12'h046, 1'b0, 1'b1, 0};
        vecs[7] = '{12'h7FF, 12'h7FF, 1'b1, 1'b0, 3};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_s_ready", s_ready, 1);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_data", m_data, 0);
        chk("reset_m_sat", m_sat, 0);

        for (int i = 0; i < 8; i++) begin
            xact(vecs[i].x, vecs[i].pre_ready, vecs[i].delay, d, s);
            chk($sformatf("vec%0d_data", i), d, vecs[i].d);
            chk($sformatf("vec%0d_sat", i), s, vecs[i].s);
        end

        // Backpressure with s_valid held high throughout
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 12'h100;
        m_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s_data = 12'h200;
        lat = 0;
        while (!m_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_latency", lat, 9);
        chk("bp_data", m_data, 12'h34B);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {m_valid, s_ready, m_sat, m_data}, {1'b1, 1'b0, 1'b0, 12'h34B});
        end
        m_ready = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        m_ready = 1'b0;
        chk("bp_release_valid", m_valid, 0);
        chk("bp_release_ready", s_ready, 1);
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (m_valid || !s_ready) saw = 1'b1;
        end
        chk("bp_no_extra", saw, 0);

        // Reset in the middle of COMPUTE, with a sample offered during reset
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 12'h100;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b1;
        s_data  = 12'h200;
        @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b0;
        chk("rst_mid_state", {s_ready, m_valid, m_sat, m_data}, {1'b1, 1'b0, 1'b0, 12'h000});
        saw = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (m_valid) saw = 1'b1;
        end
        chk("rst_no_output", saw, 0);
        xact(12'h200, 1'b0, 0, d, s);
        chk("rst_follow_data", d, 12'h56E);
        chk("rst_follow_sat", s, 0);

        // Random samples against the reference model
        for (int i = 0; i < 40; i++) begin
            x = 12'($urandom);
            r = ref_exp(x);
            xact(x, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), d, s);
            chk($sformatf("rand_x%03h_data", x), d, r[11:0]);
            chk($sformatf("rand_x%03h_sat", x), s, r[12]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
